// File: rtl/mem_sram_axi_slave_pkg.sv
// Shared encodings and lane helpers for the SRAM-backed AXI-lite-style responder.
package mem_sram_axi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ACK  = 3'd1,
    ST_RD_MEM  = 3'd2,
    ST_RD_RESP = 3'd3,
    ST_WR_ACK  = 3'd4,
    ST_WR_MEM  = 3'd5,
    ST_WR_RESP = 3'd6
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << addr_lo;
      SIZE_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   byte_en = 4'b1111;
    endcase
  endfunction

  // Copying the payload into every lane lets the byte enables pick the destination.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: lane_replicate = {4{data[7:0]}};
      SIZE_HALF: lane_replicate = {2{data[15:0]}};
      default:   lane_replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] addr_lo,
                                               input logic [31:0] word);
    case (size)
      SIZE_BYTE: lane_extract = {24'h0, word[{addr_lo, 3'b000} +: 8]};
      SIZE_HALF: lane_extract = addr_lo[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      default:   lane_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_sram_axi_slave_sp_array.sv
// Single-port DEPTHx32 RAM with per-byte write enables and one-cycle registered read.
module mem_sram_sp_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_sram_axi_slave.sv
// AXI-lite-style single-outstanding responder over an on-chip word SRAM.
// Optional SRAM wait states are enabled by defining MEM_SRAM_SLAVE_WAIT_EN.
module mem_sram_axi_slave
  import mem_sram_axi_slave_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic [1:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [1:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          arready_q, arready_d;
  logic          wack_q, wack_d;
  logic          rvalid_q, rvalid_d;
  logic          bvalid_q, bvalid_d;
  logic          mem_last;
  logic          sram_en, sram_we;
  logic [31:0]   sram_rdata;
  logic          unused_cfg;

`ifdef MEM_SRAM_SLAVE_WAIT_EN
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign mem_last = (cnt_q == CW'(WAIT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (sram_en && !mem_last) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign unused_cfg = ^{araddr[31:AW+2], awaddr[31:AW+2]};
`else
  assign mem_last   = 1'b1;
  assign unused_cfg = ^{araddr[31:AW+2], awaddr[31:AW+2], WAIT_CYCLES};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (awvalid && wvalid) state_d = ST_WR_ACK;
        else if (arvalid)      state_d = ST_RD_ACK;
      end
      ST_RD_ACK: begin
        addr_d  = araddr[AW+1:0];
        size_d  = arsize;
        state_d = ST_RD_MEM;
      end
      ST_RD_MEM:  if (mem_last) state_d = ST_RD_RESP;
      ST_RD_RESP: if (rready) state_d = ST_IDLE;
      ST_WR_ACK: begin
        addr_d  = awaddr[AW+1:0];
        size_d  = awsize;
        wdata_d = wdata;
        state_d = ST_WR_MEM;
      end
      ST_WR_MEM:  if (mem_last) state_d = ST_WR_RESP;
      ST_WR_RESP: if (bready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Handshake outputs are flops keyed off the next state, so they never see valids combinationally.
    arready_d = (state_d == ST_RD_ACK);
    wack_d    = (state_d == ST_WR_ACK);
    rvalid_d  = (state_d == ST_RD_RESP);
    bvalid_d  = (state_d == ST_WR_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= SIZE_BYTE;
      wdata_q   <= '0;
      arready_q <= 1'b0;
      wack_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      arready_q <= arready_d;
      wack_q    <= wack_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign sram_en = (state_q == ST_RD_MEM) || (state_q == ST_WR_MEM);
  assign sram_we = (state_q == ST_WR_MEM) && mem_last;

  mem_sram_sp_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .be_i    (byte_en(size_q, addr_q[1:0])),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (lane_replicate(size_q, wdata_q)),
    .rdata_o (sram_rdata)
  );

  // The RAM output register is not reset, so read data is gated by rvalid to stay zero otherwise.
  assign rdata   = rvalid_q ? lane_extract(size_q, addr_q[1:0], sram_rdata) : 32'h0;
  assign arready = arready_q;
  assign awready = wack_q;
  assign wready  = wack_q;
  assign rvalid  = rvalid_q;
  assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_mem_sram_axi_slave.sv
// Directed bench for mem_sram_axi_slave with a byte-addressed memory model and a per-cycle read-data checker.
module tb_mem_sram_axi_slave;

  localparam int DEPTH = 1024;
  localparam int WAITC = 3;
`ifdef MEM_SRAM_SLAVE_WAIT_EN
  localparam int LAT = 3 + WAITC;
`else
  localparam int LAT = 3;
`endif

  logic        clk, rst_n;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [1:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] got;

  mem_sram_axi_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] s);
    int unsigned idx = a % (DEPTH * 4);
    int unsigned wb  = idx - (idx % 4);
    int unsigned h   = wb + (((idx % 4) >= 2) ? 2 : 0);
    case (s)
      2'b00:   return {24'h0, mdl[idx]};
      2'b01:   return {16'h0, mdl[h+1], mdl[h]};
      default: return {mdl[wb+3], mdl[wb+2], mdl[wb+1], mdl[wb]};
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int unsigned idx = a % (DEPTH * 4);
    int unsigned wb  = idx - (idx % 4);
    int unsigned h   = wb + (((idx % 4) >= 2) ? 2 : 0);
    case (s)
      2'b00: mdl[idx] = d[7:0];
      2'b01: begin mdl[h] = d[7:0]; mdl[h+1] = d[15:8]; end
      default: begin
        mdl[wb] = d[7:0]; mdl[wb+1] = d[15:8]; mdl[wb+2] = d[23:16]; mdl[wb+3] = d[31:24];
      end
    endcase
  endfunction

  // Whenever read data is presented it must match the model; reads and write responses never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) check("rdata_model", rdata, exp_rdata);
      check("rb_exclusive", {31'b0, rvalid & bvalid}, 32'd0);
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                          input int wv_delay, input int b_delay);
    int k;
    awaddr = a; awsize = s; wdata = d; awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < wv_delay; i++) begin
      @(posedge clk); #1;
      check("aw_without_w", {31'b0, awready | wready}, 32'd0);
    end
    wvalid = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!(awready && wready) && k < 20);
    check("aw_latency", k, 32'd1);
    @(posedge clk); #1; k++;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, s, d);
    while (!bvalid && k < 40) begin @(posedge clk); #1; k++; end
    check("b_latency", k, LAT);
    for (int i = 0; i < b_delay; i++) begin
      @(posedge clk); #1;
      check("b_hold", {31'b0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("b_drop", {31'b0, bvalid}, 32'd0);
    $display("write addr=0x%08h size=%0d data=0x%08h", a, s, d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] s, input int r_delay,
                         output logic [31:0] data);
    int k;
    araddr = a; arsize = s; arvalid = 1'b1;
    exp_rdata = model_read(a, s);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!arready && k < 20);
    check("ar_latency", k, 32'd1);
    @(posedge clk); #1; k++;
    arvalid = 1'b0;
    while (!rvalid && k < 40) begin @(posedge clk); #1; k++; end
    check("r_latency", k, LAT);
    data = rdata;
    for (int i = 0; i < r_delay; i++) begin
      @(posedge clk); #1;
      check("r_hold", {31'b0, rvalid}, 32'd1);
      check("r_stable", rdata, data);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("r_drop", {31'b0, rvalid}, 32'd0);
    $display("read  addr=0x%08h size=%0d data=0x%08h", a, s, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    araddr = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awsize = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_wready",  {31'b0, wready},  32'd0);
    check("rst_rvalid",  {31'b0, rvalid},  32'd0);
    check("rst_bvalid",  {31'b0, bvalid},  32'd0);
    check("rst_rdata",   rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_write(32'h10, 2'b10, 32'hDEADBEEF, 0, 0);
    do_read(32'h10, 2'b10, 0, got);
    check("word_rd_lit", got, 32'hDEADBEEF);

    do_write(32'h10, 2'b10, 32'h11223344, 2, 1);
    do_write(32'h13, 2'b00, 32'hFFFFFFAA, 0, 0);
    do_read(32'h10, 2'b10, 0, got);
    check("byte_wr_lit", got, 32'hAA223344);
    do_read(32'h13, 2'b00, 0, got);
    check("byte_rd_lit", got, 32'h000000AA);
    do_read(32'h10, 2'b00, 0, got);
    check("byte_rd0_lit", got, 32'h00000044);
    do_read(32'h11, 2'b01, 0, got);
    check("half_rd_odd_lit", got, 32'h00003344);
    do_read(32'h0000_1010, 2'b10, 0, got);
    check("wrap_rd_lit", got, 32'hAA223344);
    do_read(32'h8000_1012, 2'b11, 0, got);
    check("wrap_sz3_lit", got, 32'hAA223344);

    do_write(32'h14, 2'b10, 32'h0BADF00D, 0, 0);
    do_write(32'h17, 2'b01, 32'h12345566, 0, 3);
    do_read(32'h14, 2'b10, 0, got);
    check("half_wr_lit", got, 32'h5566F00D);
    do_read(32'h16, 2'b01, 0, got);
    check("half_rd_lit", got, 32'h00005566);

    // Simultaneous read and write requests: the write is served first.
    araddr = 32'h20; arsize = 2'b10; arvalid = 1'b1;
    awaddr = 32'h20; awsize = 2'b10; wdata = 32'hCAFEF00D; awvalid = 1'b1; wvalid = 1'b1;
    model_write(32'h20, 2'b10, 32'hCAFEF00D);
    exp_rdata = model_read(32'h20, 2'b10);
    @(posedge clk); #1;
    check("col_wack", {31'b0, awready & wready}, 32'd1);
    check("col_no_ar", {31'b0, arready}, 32'd0);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    k = 0;
    while (!bvalid && k < 40) begin @(posedge clk); #1; k++; end
    check("col_bvalid", {31'b0, bvalid}, 32'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    $display("write addr=0x00000020 size=2 data=0xcafef00d (collision)");
    do_read(32'h20, 2'b10, 5, got);
    check("col_rd_lit", got, 32'hCAFEF00D);

    // Reset pulse while read data is being presented.
    araddr = 32'h10; arsize = 2'b10; arvalid = 1'b1;
    exp_rdata = model_read(32'h10, 2'b10);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!arready && k < 20);
    @(posedge clk); #1;
    arvalid = 1'b0;
    k = 0;
    while (!rvalid && k < 40) begin @(posedge clk); #1; k++; end
    check("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_arready", {31'b0, arready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rvalid", {31'b0, rvalid}, 32'd0);
    $display("reset pulse during read response");
    do_read(32'h10, 2'b10, 0, got);
    check("post_rst_rd_lit", got, 32'hAA223344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
